buzzer_scheduler: RTL

- Shares the single buzzer tone generator between N_REQ independent requesters, e.g. alarm, key-click and melody player.
- Each requester asks for one tone, given as a half-period in clk cycles and a duration in clk cycles.
- The block arbitrates round-robin, plays the winner for exactly its duration, then inserts a silent gap before the next grant.
- Outputs drive the existing tone generator's enable and half-period inputs.

---
 rtl/buzzer_scheduler.sv | 113 +++++++++++
 1 files changed

// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler: round-robin sharing of one tone generator; define BUZZ_PREEMPT_EN to let requester 0 preempt
module buzzer_scheduler #(
  parameter int N_REQ      = 3,
  parameter int PERIOD_W   = 20,
  parameter int DUR_W      = 28,
  parameter int GAP_CYCLES = 5_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*PERIOD_W-1:0] req_half_period,
  input  logic [N_REQ*DUR_W-1:0]    req_duration,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic                      tone_en,
  output logic [PERIOD_W-1:0]       tone_half_period,
  output logic                      busy
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, rr_ptr_n, owner, owner_n, pick, idx, sel;
  logic [DUR_W-1:0] dur_l, dur_l_n, dur_cnt, dur_cnt_n;
  logic [31:0] gap_cnt, gap_cnt_n;
  logic [N_REQ-1:0] grant_n, done_n;
  logic tone_en_n, preempt, load, fin;
  logic [PERIOD_W-1:0] hp_n;
  logic [PERIOD_W-1:0] hp_arr [N_REQ];
  logic [DUR_W-1:0] dur_arr [N_REQ];
  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign hp_arr[k]  = req_half_period[k*PERIOD_W +: PERIOD_W];
    assign dur_arr[k] = req_duration[k*DUR_W +: DUR_W];
  end
`ifdef BUZZ_PREEMPT_EN
  assign preempt = req[0] && state != IDLE && owner != '0;
`else
  assign preempt = 1'b0;
`endif
  assign sel  = preempt ? '0 : pick;
  assign load = preempt || (state == IDLE && |req);
  assign fin  = dur_cnt >= dur_l;
  // first requesting index at or after rr_ptr; descending loop so the nearest one wins
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr) + i) % N_REQ);
      if (req[idx]) pick = idx;
    end
  end
  // next-state and next-output computation; outputs are all registered below
  always_comb begin
    state_n   = state;
    rr_ptr_n  = rr_ptr;
    owner_n   = owner;
    dur_l_n   = dur_l;
    dur_cnt_n = dur_cnt;
    gap_cnt_n = gap_cnt;
    grant_n   = grant;
    done_n    = '0;
    tone_en_n = tone_en;
    hp_n      = tone_half_period;
    if (load) begin
      state_n   = PLAY;
      owner_n   = sel;
      grant_n   = N_REQ'(1) << sel;
      hp_n      = hp_arr[sel];
      tone_en_n = |hp_arr[sel];
      dur_l_n   = dur_arr[sel];
      dur_cnt_n = DUR_W'(1);
    end else if (state == PLAY) begin
      if (fin || !req[owner]) begin
        done_n    = fin ? grant : '0;
        grant_n   = '0;
        tone_en_n = 1'b0;
        rr_ptr_n  = IW'((int'(owner) + 1) % N_REQ);
        state_n   = (GAP_CYCLES == 0) ? IDLE : GAP;
        gap_cnt_n = 32'd1;
      end else dur_cnt_n = dur_cnt + DUR_W'(1);
    end else if (state == GAP) begin
      state_n   = (gap_cnt >= 32'(GAP_CYCLES)) ? IDLE : GAP;
      gap_cnt_n = gap_cnt + 32'd1;
    end
  end
  // state and output registers; async reset silences the buzzer immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      owner            <= '0;
      dur_l            <= '0;
      dur_cnt          <= '0;
      gap_cnt          <= '0;
      grant            <= '0;
      done             <= '0;
      tone_en          <= 1'b0;
      tone_half_period <= '0;
      busy             <= 1'b0;
    end else begin
      state            <= state_n;
      rr_ptr           <= rr_ptr_n;
      owner            <= owner_n;
      dur_l            <= dur_l_n;
      dur_cnt          <= dur_cnt_n;
      gap_cnt          <= gap_cnt_n;
      grant            <= grant_n;
      done             <= done_n;
      tone_en          <= tone_en_n;
      tone_half_period <= hp_n;
      busy             <= state_n != IDLE;
    end
  end
endmodule
